tinyrv1_inst_encoder: RTL and testbench

Inverse of the decode-side immediate generator. Accepts a TinyRV1 instruction description (op, register fields, 32-bit immediate) over a val/rdy stream. Range-checks the immediate and packs it into the I/S/B/J bit layout, then emits the 32-bit machine word over a second val/rdy stream. Used by the test-program loader and self-modifying-code tests to assemble instructions in hardware.

---
 rtl/tinyrv1_pkg.sv | 65 ++++++
 rtl/tinyrv1_imm_pack.sv | 45 ++++
 rtl/tinyrv1_inst_encoder.sv | 146 ++++++++++++++
 tb/tb_tinyrv1_inst_encoder.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyrv1_pkg.sv
// Shared TinyRV1 definitions: op codes, immediate kinds, RV32 opcode/funct fields
// and encoder error codes.
package tinyrv1_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_ADDI = 3'd1,
    OP_MUL  = 3'd2,
    OP_LW   = 3'd3,
    OP_SW   = 3'd4,
    OP_JAL  = 3'd5,
    OP_JR   = 3'd6,
    OP_BNE  = 3'd7
  } op_e;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_J    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_NONE = 3'd4;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_MUL  = 3'b000;
  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_LW   = 3'b010;
  localparam logic [2:0] F3_SW   = 3'b010;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_MUL = 7'b0000001;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RANGE = 2'd1,
    ERR_ALIGN = 2'd2
  } err_code_e;

  typedef struct packed {
    op_e         op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } req_t;

  function automatic logic [2:0] imm_type_of(op_e op);
    case (op)
      OP_ADDI, OP_LW: return IMM_I;
      OP_SW:          return IMM_S;
      OP_BNE:         return IMM_B;
      OP_JAL:         return IMM_J;
      default:        return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/tinyrv1_imm_pack.sv
// Packs a signed immediate into its I/S/B/J bit positions and flags values that
// the chosen format cannot represent.
module tinyrv1_imm_pack
  import tinyrv1_pkg::*;
(
  input  logic [31:0] imm,
  input  logic [2:0]  imm_type,
  output logic [31:0] field,
  output logic        range_err,
  output logic        align_err
);

  logic signed [31:0] simm;

  assign simm = signed'(imm);

  always_comb begin
    field     = '0;
    range_err = 1'b0;
    align_err = 1'b0;
    case (imm_type)
      IMM_I: begin
        field     = {imm[11:0], 20'b0};
        range_err = (simm < -32'sd2048) || (simm > 32'sd2047);
      end
      IMM_S: begin
        field     = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        range_err = (simm < -32'sd2048) || (simm > 32'sd2047);
      end
      // B and J drop bit 0, so odd offsets are unencodable
      IMM_B: begin
        field     = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        range_err = (simm < -32'sd4096) || (simm > 32'sd4094);
        align_err = imm[0];
      end
      IMM_J: begin
        field     = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        range_err = (simm < -32'sd1048576) || (simm > 32'sd1048574);
        align_err = imm[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/tinyrv1_inst_encoder.sv
// Two-stage TinyRV1 instruction encoder (request capture -> encoded word).
// Define TINYRV1_INST_ENCODER_STATS_EN to add saturating handshake/error counters.
module tinyrv1_inst_encoder
  import tinyrv1_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_val,
  output logic        in_rdy,
  input  logic [2:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_val,
  input  logic        out_rdy,
  output logic [31:0] out_inst,
  output logic        out_err,
  output logic [1:0]  out_err_code
`ifdef TINYRV1_INST_ENCODER_STATS_EN
  ,
  output logic [15:0] cnt_inst,
  output logic [15:0] cnt_err
`endif
);

  logic      s1_val_q, s1_val_d;
  req_t      s1_req_q, s1_req_d;
  logic      s2_val_q, s2_val_d;
  logic [31:0] s2_inst_q, s2_inst_d;
  logic      s2_err_q, s2_err_d;
  err_code_e s2_code_q, s2_code_d;

  logic        in_fire, s1_adv, out_fire;
  logic [31:0] field, base, enc_inst;
  logic        range_err, align_err;
  err_code_e   enc_code;

  assign in_rdy   = !s1_val_q || !s2_val_q || out_rdy;
  assign in_fire  = in_val && in_rdy;
  assign s1_adv   = s1_val_q && (!s2_val_q || out_rdy);
  assign out_fire = s2_val_q && out_rdy;

  tinyrv1_imm_pack u_imm_pack (
    .imm       (s1_req_q.imm),
    .imm_type  (imm_type_of(s1_req_q.op)),
    .field     (field),
    .range_err (range_err),
    .align_err (align_err)
  );

  always_comb begin
    base = '0;
    case (s1_req_q.op)
      OP_ADD:  base = {F7_ADD, s1_req_q.rs2, s1_req_q.rs1, F3_ADD, s1_req_q.rd, OPC_OP};
      OP_MUL:  base = {F7_MUL, s1_req_q.rs2, s1_req_q.rs1, F3_MUL, s1_req_q.rd, OPC_OP};
      OP_ADDI: base = {12'b0, s1_req_q.rs1, F3_ADDI, s1_req_q.rd, OPC_OP_IMM};
      OP_LW:   base = {12'b0, s1_req_q.rs1, F3_LW, s1_req_q.rd, OPC_LOAD};
      OP_SW:   base = {7'b0, s1_req_q.rs2, s1_req_q.rs1, F3_SW, 5'b0, OPC_STORE};
      OP_JAL:  base = {20'b0, s1_req_q.rd, OPC_JAL};
      OP_JR:   base = {12'b0, s1_req_q.rs1, F3_JALR, 5'b0, OPC_JALR};
      OP_BNE:  base = {7'b0, s1_req_q.rs2, s1_req_q.rs1, F3_BNE, 5'b0, OPC_BRANCH};
      default: base = '0;
    endcase
    // range errors take priority over misalignment
    if (range_err) begin
      enc_code = ERR_RANGE;
    end else if (align_err) begin
      enc_code = ERR_ALIGN;
    end else begin
      enc_code = ERR_NONE;
    end
    enc_inst = (enc_code == ERR_NONE) ? (base | field) : 32'h0000_0000;
  end

  always_comb begin
    s1_val_d  = s1_val_q;
    s1_req_d  = s1_req_q;
    s2_val_d  = s2_val_q;
    s2_inst_d = s2_inst_q;
    s2_err_d  = s2_err_q;
    s2_code_d = s2_code_q;
    if (s1_adv) s1_val_d = 1'b0;
    if (in_fire) begin
      s1_val_d = 1'b1;
      s1_req_d = '{op: op_e'(in_op), rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};
    end
    if (out_fire) s2_val_d = 1'b0;
    if (s1_adv) begin
      s2_val_d  = 1'b1;
      s2_inst_d = enc_inst;
      s2_err_d  = (enc_code != ERR_NONE);
      s2_code_d = enc_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_val_q  <= 1'b0;
      s1_req_q  <= '0;
      s2_val_q  <= 1'b0;
      s2_inst_q <= '0;
      s2_err_q  <= 1'b0;
      s2_code_q <= ERR_NONE;
    end else begin
      s1_val_q  <= s1_val_d;
      s1_req_q  <= s1_req_d;
      s2_val_q  <= s2_val_d;
      s2_inst_q <= s2_inst_d;
      s2_err_q  <= s2_err_d;
      s2_code_q <= s2_code_d;
    end
  end

  assign out_val      = s2_val_q;
  assign out_inst     = s2_inst_q;
  assign out_err      = s2_err_q;
  assign out_err_code = s2_code_q;

`ifdef TINYRV1_INST_ENCODER_STATS_EN
  logic [15:0] cnt_inst_q, cnt_inst_d, cnt_err_q, cnt_err_d;

  always_comb begin
    cnt_inst_d = cnt_inst_q;
    cnt_err_d  = cnt_err_q;
    if (out_fire) begin
      if (cnt_inst_q != 16'hFFFF) cnt_inst_d = cnt_inst_q + 16'd1;
      if (s2_err_q && (cnt_err_q != 16'hFFFF)) cnt_err_d = cnt_err_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_inst_q <= '0;
      cnt_err_q  <= '0;
    end else begin
      cnt_inst_q <= cnt_inst_d;
      cnt_err_q  <= cnt_err_d;
    end
  end

  assign cnt_inst = cnt_inst_q;
  assign cnt_err  = cnt_err_q;
`endif

endmodule

// File: tb/tb_tinyrv1_inst_encoder.sv
// Self-checking bench for tinyrv1_inst_encoder: directed vectors, backpressure,
// async reset and randomized traffic against an arithmetic reference model.
module tb_tinyrv1_inst_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_val;
  logic        in_rdy;
  logic [2:0]  in_op;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_val;
  logic        out_rdy;
  logic [31:0] out_inst;
  logic        out_err;
  logic [1:0]  out_err_code;
`ifdef TINYRV1_INST_ENCODER_STATS_EN
  logic [15:0] cnt_inst, cnt_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tinyrv1_inst_encoder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_val       (in_val),
    .in_rdy       (in_rdy),
    .in_op        (in_op),
    .in_rd        (in_rd),
    .in_rs1       (in_rs1),
    .in_rs2       (in_rs2),
    .in_imm       (in_imm),
    .out_val      (out_val),
    .out_rdy      (out_rdy),
    .out_inst     (out_inst),
    .out_err      (out_err),
    .out_err_code (out_err_code)
`ifdef TINYRV1_INST_ENCODER_STATS_EN
    ,
    .cnt_inst     (cnt_inst),
    .cnt_err      (cnt_err)
`endif
  );

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
    logic [1:0]  code;
    logic [31:0] imm;
    logic [2:0]  kind;
  } exp_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] inst;
    logic        err;
    logic [1:0]  code;
  } vec_t;

  // kind: 0 none, 1 I, 2 S, 3 B, 4 J
  function automatic int kind_of(int op);
    case (op)
      1, 3:    return 1;
      4:       return 2;
      7:       return 3;
      5:       return 4;
      default: return 0;
    endcase
  endfunction

  function automatic exp_t model(int op, int rd, int rs1, int rs2, int imm);
    exp_t        e;
    logic [31:0] u, word, ib;
    int          kind, lo, hi;
    bit          even;
    u    = imm;
    kind = kind_of(op);
    word = 0;
    ib   = 0;
    lo   = 0;
    hi   = 0;
    even = 0;
    case (op)
      0: word = (rs2 << 20) | (rs1 << 15) | (rd << 7) | 'h33;
      2: word = (1 << 25) | (rs2 << 20) | (rs1 << 15) | (rd << 7) | 'h33;
      1: word = (rs1 << 15) | (rd << 7) | 'h13;
      3: word = (rs1 << 15) | (2 << 12) | (rd << 7) | 'h03;
      4: word = (rs2 << 20) | (rs1 << 15) | (2 << 12) | 'h23;
      5: word = (rd << 7) | 'h6F;
      6: word = (rs1 << 15) | 'h67;
      default: word = (rs2 << 20) | (rs1 << 15) | (1 << 12) | 'h63;
    endcase
    case (kind)
      1: begin ib = (u & 32'hFFF) << 20; lo = -2048; hi = 2047; end
      2: begin ib = (((u >> 5) & 32'h7F) << 25) | ((u & 32'h1F) << 7); lo = -2048; hi = 2047; end
      3: begin
        ib = (((u >> 12) & 32'h1) << 31) | (((u >> 5) & 32'h3F) << 25) |
             (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 32'h1) << 7);
        lo = -4096; hi = 4094; even = 1;
      end
      4: begin
        ib = (((u >> 20) & 32'h1) << 31) | (((u >> 1) & 32'h3FF) << 21) |
             (((u >> 11) & 32'h1) << 20) | (((u >> 12) & 32'hFF) << 12);
        lo = -1048576; hi = 1048574; even = 1;
      end
      default: ;
    endcase
    e.code = 2'd0;
    if (kind != 0) begin
      if (imm < lo || imm > hi) e.code = 2'd1;
      else if (even && (imm & 1) != 0) e.code = 2'd2;
    end
    e.err  = (e.code != 2'd0);
    e.inst = e.err ? 32'h0 : (word | ib);
    e.imm  = u;
    e.kind = 3'(kind);
    return e;
  endfunction

  // Decode-side immediate generation applied to an encoded word
  function automatic logic [31:0] decode_imm(logic [31:0] w, logic [2:0] kind);
    case (kind)
      3'd1:    return {{20{w[31]}}, w[31:20]};
      3'd2:    return {{20{w[31]}}, w[31:25], w[11:7]};
      3'd3:    return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'd4:    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  function automatic int rand_imm(int kind, bit legal);
    if (kind == 0) return int'($urandom);
    if (!legal) begin
      if ((kind == 3 || kind == 4) && $urandom_range(0, 1) == 1)
        return (int'($urandom_range(0, 1000)) * 2) + 1;
      return int'($urandom);
    end
    case (kind)
      3:       return (int'($urandom_range(0, 4095)) - 2048) * 2;
      4:       return (int'($urandom_range(0, 1048575)) - 524288) * 2;
      default: return int'($urandom_range(0, 4095)) - 2048;
    endcase
  endfunction

  task automatic drive_req(int op, int rd, int rs1, int rs2, int imm);
    in_op  = op[2:0];
    in_rd  = rd[4:0];
    in_rs1 = rs1[4:0];
    in_rs2 = rs2[4:0];
    in_imm = imm;
    in_val = 1'b1;
  endtask

  // Sends one request with out_rdy high and returns what emerges; no comparisons here
  task automatic send_one(input vec_t v, output logic [31:0] inst, output logic err,
                          output logic [1:0] code, output bit timed_out);
    drive_req(int'(v.op), int'(v.rd), int'(v.rs1), int'(v.rs2), int'(v.imm));
    out_rdy   = 1'b1;
    inst      = 'x;
    err       = 'x;
    code      = 'x;
    timed_out = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (in_rdy) begin timed_out = 1'b0; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_val = 1'b0;
    if (!timed_out) begin
      timed_out = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (out_val) begin
          inst = out_inst; err = out_err; code = out_err_code;
          timed_out = 1'b0;
          break;
        end
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    in_val  = 1'b0;
    out_rdy = 1'b0;
    drive_req(0, 0, 0, 0, 0);
    in_val  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_val !== 1'b0 || out_inst !== 32'h0 || out_err !== 1'b0 || out_err_code !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_state: val=%b inst=%h err=%b code=%0d, required 0/00000000/0/0",
               out_val, out_inst, out_err, out_err_code);
    end
    checks++;
    if (in_rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_rdy: got %b, required 1", in_rdy);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    vec_t        v[16];
    logic [31:0] inst;
    logic        err;
    logic [1:0]  code;
    bit          to;
    v[0]  = '{3'd1, 5'd1, 5'd2, 5'd0, -32'sd1,      32'hFFF10093, 1'b0, 2'd0};
    v[1]  = '{3'd0, 5'd3, 5'd1, 5'd2, 32'd77,       32'h002081B3, 1'b0, 2'd0};
    v[2]  = '{3'd2, 5'd3, 5'd1, 5'd2, 32'd5,        32'h022081B3, 1'b0, 2'd0};
    v[3]  = '{3'd4, 5'd9, 5'd4, 5'd3, 32'd8,        32'h00322423, 1'b0, 2'd0};
    v[4]  = '{3'd6, 5'd5, 5'd1, 5'd7, 32'd123,      32'h00008067, 1'b0, 2'd0};
    v[5]  = '{3'd5, 5'd1, 5'd7, 5'd0, 32'd2048,     32'h001000EF, 1'b0, 2'd0};
    v[6]  = '{3'd7, 5'd0, 5'd1, 5'd0, -32'sd4,      32'hFE009EE3, 1'b0, 2'd0};
    v[7]  = '{3'd7, 5'd0, 5'd1, 5'd0, 32'd3,        32'h00000000, 1'b1, 2'd2};
    v[8]  = '{3'd1, 5'd1, 5'd2, 5'd0, 32'd2048,     32'h00000000, 1'b1, 2'd1};
    v[9]  = '{3'd1, 5'd1, 5'd0, 5'd0, -32'sd2048,   32'h80000093, 1'b0, 2'd0};
    v[10] = '{3'd1, 5'd1, 5'd0, 5'd0, 32'd2047,     32'h7FF00093, 1'b0, 2'd0};
    v[11] = '{3'd7, 5'd0, 5'd0, 5'd0, 32'd4095,     32'h00000000, 1'b1, 2'd1};
    v[12] = '{3'd7, 5'd0, 5'd0, 5'd0, -32'sd4096,   32'h80001063, 1'b0, 2'd0};
    v[13] = '{3'd5, 5'd0, 5'd0, 5'd0, -32'sd1048576, 32'h8000006F, 1'b0, 2'd0};
    v[14] = '{3'd5, 5'd0, 5'd0, 5'd0, 32'd1048574,  32'h7FFFF06F, 1'b0, 2'd0};
    v[15] = '{3'd4, 5'd0, 5'd0, 5'd0, -32'sd2049,   32'h00000000, 1'b1, 2'd1};
    for (int i = 0; i < 16; i++) begin
      send_one(v[i], inst, err, code, to);
      checks++;
      if (to) begin
        errors++;
        $display("[TB] FAIL directed_%0d_timeout: no handshake within bound", i);
      end else begin
        if (inst !== v[i].inst) begin
          errors++;
          $display("[TB] FAIL directed_%0d_inst: got %h, required %h", i, inst, v[i].inst);
        end
        checks++;
        if (err !== v[i].err || code !== v[i].code) begin
          errors++;
          $display("[TB] FAIL directed_%0d_err: got err=%b code=%0d, required err=%b code=%0d",
                   i, err, code, v[i].err, v[i].code);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e[4];
    int   rd[4], rs1[4], imm[4];
    int   idx = 0, acc = 0, got = 0;
    for (int i = 0; i < 4; i++) begin
      rd[i]  = i + 1;
      rs1[i] = 10 + i;
      imm[i] = i * 300 - 500;
      e[i]   = model(1, rd[i], rs1[i], 0, imm[i]);
    end
    out_rdy = 1'b0;
    drive_req(1, rd[0], rs1[0], 0, imm[0]);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (in_rdy !== (acc < 2)) begin
        errors++;
        $display("[TB] FAIL b2b_in_rdy_c%0d: got %b, required %b", c, in_rdy, acc < 2);
      end
      if (acc >= 2) begin
        checks++;
        if (out_val !== 1'b1 || out_inst !== e[0].inst) begin
          errors++;
          $display("[TB] FAIL b2b_hold_c%0d: got val=%b inst=%h, required 1/%h",
                   c, out_val, out_inst, e[0].inst);
        end
      end
      if (in_val && in_rdy) begin acc++; idx++; end
      @(posedge clk); #1;
      if (idx < 4) drive_req(1, rd[idx], rs1[idx], 0, imm[idx]);
      else in_val = 1'b0;
    end
    out_rdy = 1'b1;
    for (int c = 0; c < 8 && got < 4; c++) begin
      @(negedge clk);
      if (in_val && in_rdy) begin acc++; idx++; end
      checks++;
      if (out_val !== 1'b1) begin
        errors++;
        $display("[TB] FAIL b2b_drain_gap_c%0d: out_val got %b, required 1", c, out_val);
      end else begin
        if (out_inst !== e[got].inst) begin
          errors++;
          $display("[TB] FAIL b2b_order_%0d: got %h, required %h", got, out_inst, e[got].inst);
        end
        got++;
      end
      @(posedge clk); #1;
      if (idx < 4) drive_req(1, rd[idx], rs1[idx], 0, imm[idx]);
      else in_val = 1'b0;
    end
    in_val = 1'b0;
    checks++;
    if (got != 4) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d outputs, required 4", got);
    end
  endtask

  task automatic test_reset_midflight();
    out_rdy = 1'b0;
    drive_req(0, 1, 2, 3, 0);
    @(posedge clk); #1;
    drive_req(2, 4, 5, 6, 0);
    @(posedge clk); #1;
    in_val = 1'b0;
    checks++;
    if (out_val !== 1'b1 || in_rdy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_full: got val=%b in_rdy=%b, required 1/0", out_val, in_rdy);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_val !== 1'b0 || out_inst !== 32'h0 || in_rdy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_async: got val=%b inst=%h in_rdy=%b, required 0/00000000/1",
               out_val, out_inst, in_rdy);
    end
    @(posedge clk); #1;
    rst_n   = 1'b1;
    out_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (out_val !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midrst_stale_c%0d: out_val got %b, required 0", c, out_val);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e, cur;
    int   accepted = 0, hs = 0, hs_err = 0;
    int   op, rd, rs1, rs2, imm;
    cur    = '0;
    in_val = 1'b0;
    for (int cyc = 0; cyc < 8000 && !(accepted >= 1000 && q.size() == 0); cyc++) begin
      @(negedge clk);
      if (out_val && out_rdy) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("[TB] FAIL rand_unexpected: output %h with nothing outstanding", out_inst);
        end else begin
          e = q.pop_front();
          hs++;
          if (e.err) hs_err++;
          if (out_inst !== e.inst || out_err !== e.err || out_err_code !== e.code) begin
            errors++;
            $display("[TB] FAIL rand_word_%0d: got %h/%b/%0d, required %h/%b/%0d",
                     hs, out_inst, out_err, out_err_code, e.inst, e.err, e.code);
          end
          if (!e.err && e.kind != 3'd0) begin
            checks++;
            if (decode_imm(out_inst, e.kind) !== e.imm) begin
              errors++;
              $display("[TB] FAIL rand_roundtrip_%0d: decoded %h, required %h",
                       hs, decode_imm(out_inst, e.kind), e.imm);
            end
          end
        end
      end
      if (in_val && in_rdy) begin
        q.push_back(cur);
        accepted++;
      end
      @(posedge clk); #1;
      out_rdy = ($urandom_range(0, 3) != 0);
      if (accepted < 1000 && $urandom_range(0, 4) != 0) begin
        op  = int'($urandom_range(0, 7));
        rd  = int'($urandom_range(0, 31));
        rs1 = int'($urandom_range(0, 31));
        rs2 = int'($urandom_range(0, 31));
        imm = rand_imm(kind_of(op), $urandom_range(0, 7) != 0);
        cur = model(op, rd, rs1, rs2, imm);
        drive_req(op, rd, rs1, rs2, imm);
      end else begin
        in_val = 1'b0;
      end
      if (accepted >= 1000) out_rdy = 1'b1;
    end
    in_val  = 1'b0;
    out_rdy = 1'b1;
    checks++;
    if (accepted < 1000 || q.size() != 0) begin
      errors++;
      $display("[TB] FAIL rand_timeout: accepted %0d outstanding %0d, required 1000/0",
               accepted, q.size());
    end
`ifdef TINYRV1_INST_ENCODER_STATS_EN
    @(negedge clk);
    checks++;
    if (cnt_inst !== 16'(hs) || cnt_err !== 16'(hs_err)) begin
      errors++;
      $display("[TB] FAIL stats: got inst=%0d err=%0d, required %0d/%0d",
               cnt_inst, cnt_err, hs, hs_err);
    end
    @(posedge clk); #1;
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
